// File: rtl/rocc_arb_pkg.sv
// Shared types and constants for the RoCC command arbiter and its response tag FIFO.
package rocc_arb_pkg;

  localparam int unsigned XD_BIT         = 14;
  localparam int unsigned DefNumReq      = 2;
  localparam int unsigned DefTransIdBits = 3;
  localparam int unsigned DefReqIdxBits  = $clog2(DefNumReq);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Tag field widths follow the package defaults; the arbiter parameters must match them.
  typedef struct packed {
    logic                      killed;
    logic [DefReqIdxBits-1:0]  req_idx;
    logic [DefTransIdBits-1:0] trans_id;
  } rocc_tag_t;

  function automatic logic instr_xd(input logic [31:0] instr);
    return instr[XD_BIT];
  endfunction

endpackage

// File: rtl/rocc_tag_fifo.sv
// In-order FIFO of response tags; kill_all_i marks every stored entry as killed.
module rocc_tag_fifo
  import rocc_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  rocc_tag_t              tag_i,
  input  logic                   pop_i,
  input  logic                   kill_all_i,
  output rocc_tag_t              head_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  rocc_tag_t       mem_q [Depth];
  rocc_tag_t       mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full;
  logic            push_en;
  logic            pop_en;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign pop_en  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_en = push_i & (~full | pop_en);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d = mem_q;
    if (kill_all_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_d[i].killed = 1'b1;
      end
    end
    if (push_en) begin
      mem_d[wr_ptr_q] = tag_i;
    end
    wr_ptr_d = wr_ptr_q + PtrW'(push_en);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_en);
    count_d  = count_q + CntW'(push_en) - CntW'(pop_en);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rocc_cmd_arbiter.sv
// Round-robin sharing of one RoCC command/response port between NUM_REQ requesters,
// with in-order response steering through a tag FIFO.
module rocc_cmd_arbiter
  import rocc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = DefNumReq,
  parameter int unsigned TRANS_ID_BITS   = DefTransIdBits,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ*64-1:0]              req_rs1_i,
  input  logic [NUM_REQ*64-1:0]              req_rs2_i,
  input  logic [NUM_REQ*32-1:0]              req_instr_i,
  input  logic [NUM_REQ*TRANS_ID_BITS-1:0]   req_trans_id_i,
  output logic                               cmd_valid_o,
  input  logic                               cmd_ready_i,
  output logic [63:0]                        cmd_rs1_o,
  output logic [63:0]                        cmd_rs2_o,
  output logic [31:0]                        cmd_instr_o,
  input  logic                               resp_valid_i,
  output logic                               resp_ready_o,
  input  logic [63:0]                        resp_data_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic [63:0]                        rsp_data_o,
  output logic [TRANS_ID_BITS-1:0]           rsp_trans_id_o,
  output logic                               busy_o,
  output logic                               spurious_o
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned CredW = CntW + 1;

  logic [0:0]               state_q, state_d;
  logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [63:0]              rs1_q, rs1_d;
  logic [63:0]              rs2_q, rs2_d;
  logic [31:0]              instr_q, instr_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;
  logic [IdxW-1:0]          idx_q, idx_d;

  logic                     sending;
  logic [CredW-1:0]         credits_used;
  logic                     credit_ok;
  logic [NUM_REQ-1:0]       eligible;
  logic                     grant_en;
  logic                     grant_vld;
  logic                     grant;
  logic [IdxW-1:0]          grant_idx;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_empty;
  logic [CntW-1:0]          fifo_count;
  rocc_tag_t                push_tag;
  rocc_tag_t                head_tag;

  assign sending = (state_q == SEND);

  // A held xd command that has not yet been accepted already owns a credit.
  assign credits_used = {1'b0, fifo_count} + CredW'(sending & instr_xd(instr_q));
  assign credit_ok    = credits_used < CredW'(MAX_OUTSTANDING);

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      eligible[i] = req_valid_i[i] & (~req_instr_i[i*32 + int'(XD_BIT)] | credit_ok);
    end
  end

  assign grant_en = ~flush_i & (~sending | cmd_ready_i);

  // Scan downwards so the candidate closest to the pointer is the last one written.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      if (eligible[(int'(rr_ptr_q) + off) % int'(NUM_REQ)]) begin
        grant_vld = 1'b1;
        grant_idx = IdxW'((int'(rr_ptr_q) + off) % int'(NUM_REQ));
      end
    end
  end

  assign grant = grant_en & grant_vld;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready_o[i] = grant & (grant_idx == IdxW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    instr_d  = instr_q;
    tid_d    = tid_q;
    idx_d    = idx_q;

    if (grant) begin
      rs1_d    = req_rs1_i[grant_idx*64 +: 64];
      rs2_d    = req_rs2_i[grant_idx*64 +: 64];
      instr_d  = req_instr_i[grant_idx*32 +: 32];
      tid_d    = req_trans_id_i[grant_idx*TRANS_ID_BITS +: TRANS_ID_BITS];
      idx_d    = grant_idx;
      rr_ptr_d = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + IdxW'(1);
    end

    if (flush_i) begin
      state_d = IDLE;
    end else if (grant) begin
      state_d = SEND;
    end else if (sending && cmd_ready_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      instr_q  <= '0;
      tid_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      instr_q  <= instr_d;
      tid_q    <= tid_d;
      idx_q    <= idx_d;
    end
  end

  assign fifo_push = sending & cmd_ready_i & instr_xd(instr_q) & ~flush_i;
  assign fifo_pop  = resp_valid_i & ~fifo_empty;

  always_comb begin
    push_tag          = '0;
    push_tag.killed   = 1'b0;
    push_tag.req_idx  = idx_q;
    push_tag.trans_id = tid_q;
  end

  rocc_tag_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (fifo_push),
    .tag_i      (push_tag),
    .pop_i      (fifo_pop),
    .kill_all_i (flush_i),
    .head_o     (head_tag),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rsp_valid_o[i] = fifo_pop & ~head_tag.killed & (head_tag.req_idx == IdxW'(i));
    end
  end

  assign rsp_data_o     = resp_data_i;
  assign rsp_trans_id_o = head_tag.trans_id;
  assign spurious_o     = resp_valid_i & fifo_empty;
  assign resp_ready_o   = 1'b1;
  assign busy_o         = sending | ~fifo_empty;
  assign cmd_valid_o    = sending;
  assign cmd_rs1_o      = rs1_q;
  assign cmd_rs2_o      = rs2_q;
  assign cmd_instr_o    = instr_q;

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Directed bench for rocc_cmd_arbiter with command and response scoreboards.
module tb_rocc_cmd_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned TW = 3;

  localparam logic [31:0] INSTR_XD1 = 32'h0000_400B;
  localparam logic [31:0] INSTR_XD0 = 32'h0000_000B;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR*64-1:0]  req_rs1_i;
  logic [NR*64-1:0]  req_rs2_i;
  logic [NR*32-1:0]  req_instr_i;
  logic [NR*TW-1:0]  req_trans_id_i;
  logic              cmd_valid_o;
  logic              cmd_ready_i;
  logic [63:0]       cmd_rs1_o;
  logic [63:0]       cmd_rs2_o;
  logic [31:0]       cmd_instr_o;
  logic              resp_valid_i;
  logic              resp_ready_o;
  logic [63:0]       resp_data_i;
  logic [NR-1:0]     rsp_valid_o;
  logic [63:0]       rsp_data_o;
  logic [TW-1:0]     rsp_trans_id_o;
  logic              busy_o;
  logic              spurious_o;

  rocc_cmd_arbiter #(
    .NUM_REQ         (NR),
    .TRANS_ID_BITS   (TW),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_rs1_i      (req_rs1_i),
    .req_rs2_i      (req_rs2_i),
    .req_instr_i    (req_instr_i),
    .req_trans_id_i (req_trans_id_i),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_ready_i    (cmd_ready_i),
    .cmd_rs1_o      (cmd_rs1_o),
    .cmd_rs2_o      (cmd_rs2_o),
    .cmd_instr_o    (cmd_instr_o),
    .resp_valid_i   (resp_valid_i),
    .resp_ready_o   (resp_ready_o),
    .resp_data_i    (resp_data_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_trans_id_o (rsp_trans_id_o),
    .busy_o         (busy_o),
    .spurious_o     (spurious_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [31:0] instr;
  } cmd_exp_t;

  typedef struct {
    logic [NR-1:0] mask;
    logic [TW-1:0] tid;
    logic          spur;
    logic [63:0]   data;
  } rsp_exp_t;

  cmd_exp_t cmd_q[$];
  rsp_exp_t rsp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [31:0] instr,
                         input logic [TW-1:0] tid);
    req_valid_i[i]             = v;
    req_rs1_i[i*64 +: 64]      = rs1;
    req_rs2_i[i*64 +: 64]      = rs2;
    req_instr_i[i*32 +: 32]    = instr;
    req_trans_id_i[i*TW +: TW] = tid;
  endtask

  task automatic exp_cmd(input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [31:0] instr);
    cmd_exp_t e;
    e.rs1   = rs1;
    e.rs2   = rs2;
    e.instr = instr;
    cmd_q.push_back(e);
  endtask

  task automatic drive_resp(input logic [63:0] data, input logic [NR-1:0] mask,
                            input logic [TW-1:0] tid, input logic spur);
    rsp_exp_t e;
    resp_valid_i = 1'b1;
    resp_data_i  = data;
    e.mask = mask;
    e.tid  = tid;
    e.spur = spur;
    e.data = data;
    rsp_q.push_back(e);
  endtask

  // Command scoreboard: every accepted command must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni && cmd_valid_o && cmd_ready_i && !flush_i) begin
      check_eq("cmd_expected", 64'(cmd_q.size() > 0), 64'd1);
      if (cmd_q.size() > 0) begin
        cmd_exp_t e;
        e = cmd_q.pop_front();
        check_eq("cmd_rs1", cmd_rs1_o, e.rs1);
        check_eq("cmd_rs2", cmd_rs2_o, e.rs2);
        check_eq("cmd_instr", 64'(cmd_instr_o), 64'(e.instr));
      end
    end
  end

  // Response scoreboard: routing, trans_id and spurious flag for every response.
  always @(negedge clk_i) begin
    if (rst_ni && resp_valid_i) begin
      check_eq("rsp_expected", 64'(rsp_q.size() > 0), 64'd1);
      if (rsp_q.size() > 0) begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        check_eq("rsp_valid", 64'(rsp_valid_o), 64'(e.mask));
        check_eq("rsp_spurious", 64'(spurious_o), 64'(e.spur));
        check_eq("rsp_data", rsp_data_o, e.data);
        if (!e.spur) check_eq("rsp_trans_id", 64'(rsp_trans_id_o), 64'(e.tid));
      end
    end
  end

  initial begin
    rst_ni         = 1'b0;
    flush_i        = 1'b0;
    req_valid_i    = '0;
    req_rs1_i      = '0;
    req_rs2_i      = '0;
    req_instr_i    = '0;
    req_trans_id_i = '0;
    cmd_ready_i    = 1'b0;
    resp_valid_i   = 1'b0;
    resp_data_i    = '0;

    #2;
    check_eq("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready_o), 64'd0);
    check_eq("rst_resp_ready", 64'(resp_ready_o), 64'd1);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_spurious", 64'(spurious_o), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("rst_cmd_rs1", cmd_rs1_o, 64'd0);
    check_eq("rst_rsp_tid", 64'(rsp_trans_id_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single xd command and its response.
    next_cycle();
    cmd_ready_i = 1'b1;
    set_req(0, 1'b1, 64'h11, 64'h22, INSTR_XD1, 3'd5);
    exp_cmd(64'h11, 64'h22, INSTR_XD1);
    @(negedge clk_i);
    check_eq("t1_grant", 64'(req_ready_o), 64'b01);
    check_eq("t1_no_cmd_yet", 64'(cmd_valid_o), 64'd0);
    next_cycle();
    set_req(0, 1'b0, 64'h0, 64'h0, 32'h0, 3'd0);
    @(negedge clk_i);
    check_eq("t1_cmd_valid", 64'(cmd_valid_o), 64'd1);
    next_cycle();
    @(negedge clk_i);
    check_eq("t1_idle", 64'(cmd_valid_o), 64'd0);
    check_eq("t1_busy_tag", 64'(busy_o), 64'd1);
    next_cycle();
    drive_resp(64'hAB, 2'b01, 3'd5, 1'b0);
    @(negedge clk_i);
    next_cycle();
    resp_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("t1_busy_done", 64'(busy_o), 64'd0);

    // Round-robin alternation, xd=0; pointer sits at 1 after the previous grant.
    next_cycle();
    set_req(0, 1'b1, 64'hA0, 64'hA2, INSTR_XD0, 3'd1);
    set_req(1, 1'b1, 64'hB1, 64'hB2, INSTR_XD0 | 32'h80, 3'd2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      if (k % 2 == 0) exp_cmd(64'hB1, 64'hB2, INSTR_XD0 | 32'h80);
      else            exp_cmd(64'hA0, 64'hA2, INSTR_XD0);
      @(negedge clk_i);
      check_eq("t2_grant", 64'(req_ready_o), (k % 2 == 0) ? 64'b10 : 64'b01);
    end
    next_cycle();
    set_req(0, 1'b0, 64'h0, 64'h0, 32'h0, 3'd0);
    set_req(1, 1'b0, 64'h0, 64'h0, 32'h0, 3'd0);
    @(negedge clk_i);
    check_eq("t2_last_cmd", 64'(cmd_valid_o), 64'd1);
    next_cycle();
    @(negedge clk_i);
    check_eq("t2_drained", 64'(busy_o), 64'd0);

    // Credit limit: four xd commands fill the FIFO.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_req(0, 1'b1, 64'h300 + 64'(k), 64'h0, INSTR_XD1, 3'(k));
      exp_cmd(64'h300 + 64'(k), 64'h0, INSTR_XD1);
      @(negedge clk_i);
      check_eq("t3_fill_grant", 64'(req_ready_o), 64'b01);
    end
    next_cycle();
    set_req(0, 1'b1, 64'h304, 64'h0, INSTR_XD1, 3'd4);
    set_req(1, 1'b1, 64'h3B0, 64'h0, INSTR_XD0, 3'd7);
    exp_cmd(64'h3B0, 64'h0, INSTR_XD0);
    @(negedge clk_i);
    check_eq("t3_xd0_granted", 64'(req_ready_o), 64'b10);
    next_cycle();
    set_req(1, 1'b0, 64'h0, 64'h0, 32'h0, 3'd0);
    @(negedge clk_i);
    check_eq("t3_blocked_send", 64'(req_ready_o), 64'b00);
    next_cycle();
    drive_resp(64'h5A, 2'b01, 3'd0, 1'b0);
    @(negedge clk_i);
    check_eq("t3_blocked_idle", 64'(req_ready_o), 64'b00);
    check_eq("t3_idle", 64'(cmd_valid_o), 64'd0);
    next_cycle();
    resp_valid_i = 1'b0;
    exp_cmd(64'h304, 64'h0, INSTR_XD1);
    @(negedge clk_i);
    check_eq("t3_credit_freed", 64'(req_ready_o), 64'b01);
    next_cycle();
    set_req(0, 1'b0, 64'h0, 64'h0, 32'h0, 3'd0);
    @(negedge clk_i);
    check_eq("t3_fifth_cmd", 64'(cmd_valid_o), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      drive_resp(64'h60 + 64'(k), 2'b01, 3'(k), 1'b0);
      @(negedge clk_i);
    end
    next_cycle();
    resp_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("t3_drained", 64'(busy_o), 64'd0);

    // Back-pressure then flush of the held command.
    next_cycle();
    cmd_ready_i = 1'b0;
    set_req(1, 1'b1, 64'hC1, 64'hC2, INSTR_XD1, 3'd6);
    @(negedge clk_i);
    check_eq("t4_grant", 64'(req_ready_o), 64'b10);
    next_cycle();
    set_req(1, 1'b0, 64'h0, 64'h0, 32'h0, 3'd0);
    set_req(0, 1'b1, 64'hD0, 64'h0, INSTR_XD0, 3'd0);
    @(negedge clk_i);
    check_eq("t4_stall_valid", 64'(cmd_valid_o), 64'd1);
    check_eq("t4_stall_rs1", cmd_rs1_o, 64'hC1);
    check_eq("t4_stall_ready", 64'(req_ready_o), 64'b00);
    next_cycle();
    flush_i     = 1'b1;
    cmd_ready_i = 1'b1;
    @(negedge clk_i);
    check_eq("t4_flush_nogrant", 64'(req_ready_o), 64'b00);
    check_eq("t4_flush_rs1", cmd_rs1_o, 64'hC1);
    next_cycle();
    flush_i = 1'b0;
    set_req(0, 1'b0, 64'h0, 64'h0, 32'h0, 3'd0);
    @(negedge clk_i);
    check_eq("t4_dropped", 64'(cmd_valid_o), 64'd0);
    check_eq("t4_no_push", 64'(busy_o), 64'd0);

    // Two outstanding tags killed by a flush.
    next_cycle();
    set_req(0, 1'b1, 64'h500, 64'h0, INSTR_XD1, 3'd2);
    exp_cmd(64'h500, 64'h0, INSTR_XD1);
    @(negedge clk_i);
    check_eq("t5_grant_a", 64'(req_ready_o), 64'b01);
    next_cycle();
    set_req(0, 1'b1, 64'h501, 64'h0, INSTR_XD1, 3'd3);
    exp_cmd(64'h501, 64'h0, INSTR_XD1);
    @(negedge clk_i);
    check_eq("t5_grant_b", 64'(req_ready_o), 64'b01);
    next_cycle();
    set_req(0, 1'b0, 64'h0, 64'h0, 32'h0, 3'd0);
    @(negedge clk_i);
    next_cycle();
    flush_i = 1'b1;
    @(negedge clk_i);
    check_eq("t5_busy_tags", 64'(busy_o), 64'd1);
    next_cycle();
    flush_i = 1'b0;
    drive_resp(64'h77, 2'b00, 3'd2, 1'b0);
    @(negedge clk_i);
    next_cycle();
    drive_resp(64'h78, 2'b00, 3'd3, 1'b0);
    @(negedge clk_i);
    next_cycle();
    resp_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("t5_drained", 64'(busy_o), 64'd0);

    // Spurious response, then reset in the middle of a held command.
    next_cycle();
    drive_resp(64'hEE, 2'b00, 3'd0, 1'b1);
    @(negedge clk_i);
    next_cycle();
    resp_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("t6_spur_pulse_end", 64'(spurious_o), 64'd0);
    next_cycle();
    cmd_ready_i = 1'b0;
    set_req(0, 1'b1, 64'h600, 64'h601, INSTR_XD1, 3'd1);
    @(negedge clk_i);
    check_eq("t6_grant", 64'(req_ready_o), 64'b01);
    next_cycle();
    set_req(0, 1'b0, 64'h0, 64'h0, 32'h0, 3'd0);
    @(negedge clk_i);
    check_eq("t6_send", 64'(cmd_valid_o), 64'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check_eq("t6_rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
    check_eq("t6_rst_busy", 64'(busy_o), 64'd0);
    check_eq("t6_rst_req_ready", 64'(req_ready_o), 64'd0);
    check_eq("t6_rst_rs1", cmd_rs1_o, 64'd0);
    check_eq("t6_rst_instr", 64'(cmd_instr_o), 64'd0);

    check_eq("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check_eq("rsp_q_empty", 64'(rsp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
